// File: rtl/inst_encoder_if.sv
// inst_encoder_if: request/response bundle for the RV32I instruction encoder.
// Master drives decoded fields and out_ready; slave returns encoded words and counters.
interface inst_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        out_err;
    logic [15:0] enc_count;
    logic [15:0] err_count;

    modport master (
        output in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, out_ready,
        input  in_ready, out_valid, out_inst, out_err, enc_count, err_count
    );

    modport slave (
        input  in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, out_ready,
        output in_ready, out_valid, out_inst, out_err, enc_count, err_count
    );
endinterface

// File: rtl/inst_encoder.sv
// inst_encoder: scatters decoded RV32I fields into instruction words through a 2-entry FIFO.
// Define INST_ENCODER_RANGE_CHECK_EN to flag immediates that do not fit their format.
module inst_encoder (
    input  logic          clk,
    input  logic          rst_n,
    inst_encoder_if.slave bus
);
    localparam logic [6:0]  OP_R     = 7'b0110011;
    localparam logic [6:0]  OP_I     = 7'b0010011;
    localparam logic [6:0]  OP_LD    = 7'b0000011;
    localparam logic [6:0]  OP_JALR  = 7'b1100111;
    localparam logic [6:0]  OP_S     = 7'b0100011;
    localparam logic [6:0]  OP_B     = 7'b1100011;
    localparam logic [6:0]  OP_LUI   = 7'b0110111;
    localparam logic [6:0]  OP_AUIPC = 7'b0010111;
    localparam logic [6:0]  OP_JAL   = 7'b1101111;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic [31:0] imm;
    logic [31:0] enc_inst;
    logic        enc_err;
    logic        known;
    logic        is_shift;
    logic [32:0] mem_q [2];
    logic [32:0] mem_d [2];
    logic        head_q, head_d;
    logic        tail_q, tail_d;
    logic [1:0]  count_q, count_d;
    logic [15:0] enc_count_q, enc_count_d;
    logic [15:0] err_count_q, err_count_d;
    logic        push, pop;

    assign imm      = bus.in_imm;
    assign is_shift = (bus.in_opcode == OP_I) && (bus.in_funct3[1:0] == 2'b01);

    always_comb begin
        known    = 1'b1;
        enc_inst = NOP;
        case (bus.in_opcode)
            OP_R:
                enc_inst = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
            OP_I, OP_LD, OP_JALR:
                enc_inst = is_shift ? {bus.in_funct7, imm[4:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode}
                                    : {imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
            OP_S:
                enc_inst = {imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3, imm[4:0], bus.in_opcode};
            OP_B:
                enc_inst = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3, imm[4:1], imm[11], bus.in_opcode};
            OP_LUI, OP_AUIPC:
                enc_inst = {imm[31:12], bus.in_rd, bus.in_opcode};
            OP_JAL:
                enc_inst = {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd, bus.in_opcode};
            default:
                known = 1'b0;
        endcase
    end

`ifdef INST_ENCODER_RANGE_CHECK_EN
    logic signed [31:0] simm;
    logic               range_err;

    assign simm = signed'(bus.in_imm);

    // Shift amounts compare unsigned so negative values also land out of range.
    always_comb begin
        range_err = 1'b0;
        case (bus.in_opcode)
            OP_I, OP_LD, OP_JALR:
                range_err = is_shift ? (imm > 32'd31) : (simm < -32'sd2048 || simm > 32'sd2047);
            OP_S:
                range_err = simm < -32'sd2048 || simm > 32'sd2047;
            OP_B:
                range_err = simm < -32'sd4096 || simm > 32'sd4094 || imm[0];
            OP_LUI, OP_AUIPC:
                range_err = |imm[11:0];
            OP_JAL:
                range_err = simm < -32'sd1048576 || simm > 32'sd1048574 || imm[0];
            default:
                range_err = 1'b0;
        endcase
    end

    assign enc_err = !known || range_err;
`else
    assign enc_err = !known;
`endif

    // in_ready looks only at the registered count, so popping a full FIFO still stalls input.
    assign bus.in_ready  = count_q != 2'd2;
    assign bus.out_valid = count_q != 2'd0;
    assign {bus.out_err, bus.out_inst} = bus.out_valid ? mem_q[head_q] : 33'd0;
    assign bus.enc_count = enc_count_q;
    assign bus.err_count = err_count_q;
    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[tail_q] = {enc_err, enc_inst};
        tail_d      = push ? ~tail_q : tail_q;
        head_d      = pop ? ~head_q : head_q;
        count_d     = count_q + {1'b0, push} - {1'b0, pop};
        enc_count_d = enc_count_q + {15'd0, push};
        err_count_d = err_count_q + {15'd0, push && enc_err};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q[0]    <= '0;
            mem_q[1]    <= '0;
            head_q      <= 1'b0;
            tail_q      <= 1'b0;
            count_q     <= 2'd0;
            enc_count_q <= 16'd0;
            err_count_q <= 16'd0;
        end else begin
            mem_q       <= mem_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            enc_count_q <= enc_count_d;
            err_count_q <= err_count_d;
        end
    end
endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder: directed vector table, corner sequences and random traffic
// against a queue-based reference model of the encoder.
module tb_inst_encoder;
    typedef struct {
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] e_inst;
        logic        e_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic chk_en = 1'b0;
    int   errors = 0;
    int   checks = 0;

    inst_encoder_if bus ();
    inst_encoder dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    always #5 clk = ~clk;

    logic [32:0] m_q [$];
    logic [15:0] m_enc = 16'd0;
    logic [15:0] m_err = 16'd0;
    vec_t        cur;
    logic [32:0] m_e;
    logic        acc, pp;
    vec_t        tbl [9];
    logic [6:0]  ops [9] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};

`ifdef INST_ENCODER_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                                input logic [31:0] imm, input logic [31:0] e_inst, input logic e_err);
        vec_t v;
        v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.f3 = f3; v.f7 = f7; v.imm = imm;
        v.e_inst = e_inst; v.e_err = e_err;
        return v;
    endfunction

    // Reference: format layouts from the ISA, range limits with plain integer arithmetic.
    function automatic logic [32:0] ref_enc(input vec_t r);
        logic [31:0] i;
        logic [31:0] w;
        logic        bad;
        int          v;
        i = r.imm;
        v = $signed(r.imm);
        bad = 1'b0;
        w = 32'h13;
        case (r.op)
            7'h33: w = {r.f7, r.rs2, r.rs1, r.f3, r.rd, r.op};
            7'h13, 7'h03, 7'h67:
                if (r.op == 7'h13 && (r.f3 == 3'd1 || r.f3 == 3'd5)) begin
                    w = {r.f7, i[4:0], r.rs1, r.f3, r.rd, r.op};
                    bad = v < 0 || v > 31;
                end else begin
                    w = {i[11:0], r.rs1, r.f3, r.rd, r.op};
                    bad = v < -2048 || v > 2047;
                end
            7'h23: begin
                w = {i[11:5], r.rs2, r.rs1, r.f3, i[4:0], r.op};
                bad = v < -2048 || v > 2047;
            end
            7'h63: begin
                w = {i[12], i[10:5], r.rs2, r.rs1, r.f3, i[4:1], i[11], r.op};
                bad = v < -4096 || v > 4094 || v % 2 != 0;
            end
            7'h37, 7'h17: begin
                w = {i[31:12], r.rd, r.op};
                bad = v % 4096 != 0;
            end
            7'h6F: begin
                w = {i[20], i[10:1], i[11], i[19:12], r.rd, r.op};
                bad = v < -1048576 || v > 1048574 || v % 2 != 0;
            end
            default: return {1'b1, 32'h13};
        endcase
        return {RC & bad, w};
    endfunction

    task automatic drive(input vec_t v);
        bus.in_opcode = v.op; bus.in_rd = v.rd; bus.in_rs1 = v.rs1; bus.in_rs2 = v.rs2;
        bus.in_funct3 = v.f3; bus.in_funct7 = v.f7; bus.in_imm = v.imm;
    endtask

    task automatic send(input vec_t v);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        drive(v);
        bus.in_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.in_ready) begin ok = 1'b1; break; end
        end
        if (!ok) begin errors++; checks++; $display("FAIL send_timeout: in_ready stuck low"); end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    function automatic vec_t rnd_vec();
        vec_t v;
        int   k;
        k = $urandom_range(0, 9);
        v.op = (k == 9) ? 7'($urandom) : ops[k];
        v.rd = 5'($urandom); v.rs1 = 5'($urandom); v.rs2 = 5'($urandom);
        v.f3 = 3'($urandom); v.f7 = 7'($urandom);
        case ($urandom_range(0, 4))
            0: v.imm = $urandom;
            1: v.imm = 32'($urandom_range(0, 8191)) - 32'd4096;
            2: v.imm = 32'($urandom_range(0, 40));
            3: v.imm = $urandom & 32'hFFFF_F000;
            default: v.imm = 32'($urandom_range(0, 2097151)) - 32'd1048576;
        endcase
        v.e_inst = 32'd0; v.e_err = 1'b0;
        return v;
    endfunction

    // Scoreboard: compare state left by the last edge, then predict the next edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", {31'd0, bus.in_ready}, {31'd0, m_q.size() < 2});
            chk("out_valid", {31'd0, bus.out_valid}, {31'd0, m_q.size() != 0});
            if (m_q.size() != 0) begin
                chk("out_inst", bus.out_inst, m_q[0][31:0]);
                chk("out_err", {31'd0, bus.out_err}, {31'd0, m_q[0][32]});
            end
            chk("enc_count", {16'd0, bus.enc_count}, {16'd0, m_enc});
            chk("err_count", {16'd0, bus.err_count}, {16'd0, m_err});
            if (!rst_n) begin
                m_q.delete();
                m_enc = 16'd0;
                m_err = 16'd0;
            end else begin
                cur.op = bus.in_opcode; cur.rd = bus.in_rd; cur.rs1 = bus.in_rs1; cur.rs2 = bus.in_rs2;
                cur.f3 = bus.in_funct3; cur.f7 = bus.in_funct7; cur.imm = bus.in_imm;
                acc = bus.in_valid && m_q.size() < 2;
                pp  = bus.out_ready && m_q.size() != 0;
                if (pp) void'(m_q.pop_front());
                if (acc) begin
                    m_e = ref_enc(cur);
                    m_q.push_back(m_e);
                    m_enc = m_enc + 16'd1;
                    m_err = m_err + {15'd0, m_e[32]};
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] base;
        int          terr;
        tbl[0] = mk(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5,         32'h0050_0093, 1'b0);
        tbl[1] = mk(7'h23, 5'd0, 5'd3, 5'd2, 3'd2, 7'd0, -32'sd4,       32'hFE21_AE23, 1'b0);
        tbl[2] = mk(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8,         32'h0020_8463, 1'b0);
        tbl[3] = mk(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,      32'h0010_00EF, 1'b0);
        tbl[4] = mk(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0);
        tbl[5] = mk(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096,      32'h0000_0093, RC);
        tbl[6] = mk(7'h7F, 5'd3, 5'd4, 5'd5, 3'd1, 7'd9, 32'd77,        32'h0000_0013, 1'b1);
        tbl[7] = mk(7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 32'hDEAD_BEEF, 32'h4031_00B3, 1'b0);
        tbl[8] = mk(7'h13, 5'd1, 5'd2, 5'd0, 3'd5, 7'h20, 32'd3,        32'h4031_5093, 1'b0);

        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        drive(tbl[0]);
        repeat (2) @(posedge clk);
        #1 chk_en = 1'b1;
        @(negedge clk);
        chk("rst_out_inst", bus.out_inst, 32'd0);
        chk("rst_out_err", {31'd0, bus.out_err}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        terr = 0;
        for (int k = 0; k < 9; k++) begin
            send(tbl[k]);
            @(negedge clk);
            terr += int'(tbl[k].e_err);
            chk($sformatf("vec%0d_valid", k), {31'd0, bus.out_valid}, 32'd1);
            chk($sformatf("vec%0d_inst", k), bus.out_inst, tbl[k].e_inst);
            chk($sformatf("vec%0d_err", k), {31'd0, bus.out_err}, {31'd0, tbl[k].e_err});
            chk($sformatf("vec%0d_enc_count", k), {16'd0, bus.enc_count}, 32'(k + 1));
            chk($sformatf("vec%0d_err_count", k), {16'd0, bus.err_count}, 32'(terr));
        end

        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        base = m_enc;
        drive(tbl[0]); bus.in_valid = 1'b1;
        @(negedge clk) chk("bp_ready0", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk); #1 drive(tbl[1]);
        @(negedge clk) chk("bp_ready1", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk); #1 drive(tbl[2]);
        @(negedge clk) chk("bp_full", {31'd0, bus.in_ready}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_accepted", {16'd0, bus.enc_count}, {16'd0, base + 16'd2});
        chk("bp_head_stable", bus.out_inst, tbl[0].e_inst);
        @(posedge clk); #1 bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_full_popping", {31'd0, bus.in_ready}, 32'd0);
        chk("bp_drain0", bus.out_inst, tbl[0].e_inst);
        @(negedge clk);
        chk("bp_drain1", bus.out_inst, tbl[1].e_inst);
        chk("pushpop_ready", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk); #1 bus.in_valid = 1'b0;
        @(negedge clk);
        chk("pushpop_count1", {31'd0, bus.out_valid}, 32'd1);
        chk("bp_drain2", bus.out_inst, tbl[2].e_inst);
        repeat (3) @(posedge clk);

        #1 bus.out_ready = 1'b0;
        drive(tbl[3]); bus.in_valid = 1'b1;
        @(posedge clk); #1 drive(tbl[6]);
        @(posedge clk); #1 rst_n = 1'b0;
        @(negedge clk) chk("pre_rst_full", {31'd0, bus.in_ready}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1; bus.in_valid = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("mid_rst_inst", bus.out_inst, 32'd0);
        chk("mid_rst_err", {31'd0, bus.out_err}, 32'd0);
        chk("mid_rst_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("mid_rst_enc", {16'd0, bus.enc_count}, 32'd0);
        chk("mid_rst_errc", {16'd0, bus.err_count}, 32'd0);

        for (int n = 0; n < 600; n++) begin
            @(posedge clk); #1;
            drive(rnd_vec());
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            rst_n = ($urandom_range(0, 79) != 0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("final_empty", {31'd0, bus.out_valid}, 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/inst_encoder.md
# inst_encoder

Pipelined RV32I instruction encoder: the inverse of the decode-stage immediate extender. It accepts decoded fields (opcode, registers, functs, 32-bit sign-extended immediate) over a valid/ready handshake. It scatters the immediate into the bit positions for the opcode's format and streams 32-bit instruction words out of a 2-entry FIFO. It sits in front of the debug/boot instruction-injection path that feeds IF.

## Interface
- No parameters; FIFO depth fixed at 2, counter width fixed at 16.
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous reset, active-low
- in_valid  in  1  request valid
- in_ready  out  1  encoder can accept; high when FIFO count < 2
- in_opcode  in  7  instruction opcode
- in_rd, in_rs1, in_rs2  in  5 each  register fields
- in_funct3  in  3  funct3
- in_funct7  in  7  funct7; also imm[11:5] for I-type shifts
- in_imm  in  32  immediate, two's complement, same value the decoder would produce
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head
- out_inst  out  32  encoded instruction at FIFO head
- out_err  out  1  head flagged as encode error
- enc_count  out  16  instructions accepted since reset, wraps
- err_count  out  16  accepted requests flagged as error, wraps

## Operation
- Accept on in_valid & in_ready. Encode combinationally and write {inst, err} to the FIFO tail in the same cycle.
- Formats, with imm = in_imm:
  - R (0110011): {funct7, rs2, rs1, funct3, rd, opcode}; in_imm ignored.
  - I (0010011, 0000011, 1100111): {imm[11:0], rs1, funct3, rd, opcode}.
  - I-shift (0010011 with funct3 001/101): {funct7, imm[4:0], rs1, funct3, rd, opcode}.
  - S (0100011): {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - B (1100011): {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
  - U (0110111, 0010111): {imm[31:12], rd, opcode}.
  - J (1101111): {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
- Unknown opcode: out_inst = 32'h00000013 (NOP), err = 1. This applies regardless of configuration.
- Dropped immediate bits are truncated silently unless range checking is compiled in (see Configuration).
- FIFO:
  - 2 entries with a head pointer, a tail pointer and a 2-bit count.
  - Push and pop in the same cycle leave count unchanged.
  - in_ready = (count != 2) and depends only on registered count. There is no combinational out_ready-to-in_ready path, so a full FIFO that is popping still refuses input that cycle.
  - Pointers wrap 1 -> 0.
- enc_count increments on every accept. err_count increments on every accept whose err = 1. Both wrap at 16'hFFFF -> 0.

## Timing
- Latency: request accepted at edge N appears at out_* after edge N (visible in cycle N+1). This applies even with an empty FIFO; there is no bypass.
- Throughput: 1 per cycle while out_ready is held high.
- out_inst and out_err are stable while out_valid & !out_ready.
- Reset (rst_n low at a rising edge), also mid-stream:
  - count, pointers, enc_count and err_count go to 0.
  - out_valid = 0, out_inst = 0, out_err = 0.
  - in_ready = 1 from the first cycle after reset.
  - In-flight entries are discarded. Requests presented during reset are not accepted.

## Configuration
- INST_ENCODER_RANGE_CHECK_EN defined, err = 1 for an accepted request when any of the following holds:
  - I: imm not in [-2048, 2047].
  - I-shift: imm not in [0, 31].
  - S: imm not in [-2048, 2047].
  - B: imm not in [-4096, 4094] or imm[0] != 0.
  - U: imm[11:0] != 0.
  - J: imm not in [-1048576, 1048574] or imm[0] != 0.
- With the macro defined, the encoded word is still the truncated encoding; only the flag and err_count change.
- INST_ENCODER_RANGE_CHECK_EN undefined: no range logic. err is set only for unknown opcodes.

## Test plan
- Single requests, out_ready high, one cycle latency each:
  - addi (0010011), rd=1, rs1=0, f3=0, imm=5 -> out_inst 0x00500093, err 0.
  - sw (0100011), rs1=3, rs2=2, f3=2, imm=-4 -> 0xFE21AE23.
- beq (1100011), rs1=1, rs2=2, imm=8 -> 0x00208463.
- jal (1101111), rd=1, imm=2048 -> 0x001000EF.
- lui (0110111), rd=5, imm=0x12345000 -> 0x123452B7.
- Range check, addi rd=1, imm=4096:
  - With macro defined: out_inst 0x00000093, out_err 1, err_count 1.
  - With macro undefined: out_err 0.
  - Opcode 7'h7F: 0x00000013, err 1 in both builds.
- Backpressure:
  - Hold out_ready=0 and push 3 back-to-back: 2 accepted, in_ready low from the cycle after the second accept.
  - Release out_ready: words drain in order, one per cycle.
  - Simultaneous push/pop at count 1 keeps count 1.
- Reset mid-stream: assert rst_n=0 with 2 entries queued -> next cycle out_valid 0, out_inst 0, in_ready 1, enc_count 0.
